// File: rtl/point_rotator.sv
// point_rotator
//   Rotates one signed 2-D point counter-clockwise by an angle code. It makes
//   two lookups through the attached quarter-wave sine table: sin(theta), then
//   cos(theta) = sin(theta + 90 deg). It then forms the rotated point with a
//   single multiply-accumulate step and returns it over a valid/ready handshake.
//   Only one transaction is in flight at a time.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   in_valid   request valid
//   in_ready   block can accept a request (IDLE only)
//   in_x/in_y  signed input point, COORD_W bits
//   in_angle   rotation angle, 4*ROM_DEPTH codes per full circle
//   sin_id     lookup index driven to sine_table.id
//   sin_data   signed Q(ROM_WIDTH).(ROM_WIDTH) lookup result from sine_table.data
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   out_x/y    signed rotated point, saturated to COORD_W bits
module point_rotator #(
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int ADDRW     = $clog2(4 * ROM_DEPTH),
    parameter int COORD_W   = 11,
    parameter int TABLE_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COORD_W-1:0]     in_x,
    input  logic [COORD_W-1:0]     in_y,
    input  logic [ADDRW-1:0]       in_angle,
    output logic [ADDRW-1:0]       sin_id,
    input  logic [2*ROM_WIDTH-1:0] sin_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COORD_W-1:0]     out_x,
    output logic [COORD_W-1:0]     out_y
);

    localparam int DW = 2 * ROM_WIDTH;
    localparam int PW = COORD_W + 2 * ROM_WIDTH + 1;
    // Wide enough to hold the value TABLE_LAT, even when TABLE_LAT is 0.
    localparam int CW = $clog2(TABLE_LAT + 2);

    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (COORD_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(1 << (COORD_W - 1)));

    typedef enum logic [2:0] {
        IDLE,
        SIN_WAIT,
        COS_WAIT,
        MULT,
        OUT
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]            cnt;
    logic                     cnt_last;
    logic                     accept, latch_s, latch_c, do_mult;

    logic [COORD_W-1:0]       x_r, y_r;
    logic [ADDRW-1:0]         angle_r;
    logic [DW-1:0]            s_r, c_r;

    logic signed [PW-1:0]     x_ext, y_ext, s_ext, c_ext;
    logic signed [PW-1:0]     px_full, py_full, px_sh, py_sh;

    // Clamp a shifted full-width result into the signed COORD_W range.
    function automatic logic [COORD_W-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[COORD_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[COORD_W-1:0];
        else
            return v[COORD_W-1:0];
    endfunction

    assign cnt_last = (cnt == CW'(TABLE_LAT));

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        latch_s    = 1'b0;
        latch_c    = 1'b0;
        do_mult    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = SIN_WAIT;
                end
            end
            SIN_WAIT: begin
                if (cnt_last) begin
                    latch_s    = 1'b1;
                    next_state = COS_WAIT;
                end
            end
            COS_WAIT: begin
                if (cnt_last) begin
                    latch_c    = 1'b1;
                    next_state = MULT;
                end
            end
            MULT: begin
                do_mult    = 1'b1;
                next_state = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and table wait counter. The counter restarts on every
    // state change, so each WAIT state lasts exactly TABLE_LAT+1 cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state != next_state)
                cnt <= '0;
            else if (state == SIN_WAIT || state == COS_WAIT)
                cnt <= cnt + 1'b1;
        end
    end

    // Sign-extend operands to the full accumulator width.
    always_comb begin
        x_ext   = {{(PW - COORD_W){x_r[COORD_W-1]}}, x_r};
        y_ext   = {{(PW - COORD_W){y_r[COORD_W-1]}}, y_r};
        s_ext   = {{(PW - DW){s_r[DW-1]}}, s_r};
        c_ext   = {{(PW - DW){c_r[DW-1]}}, c_r};
        px_full = x_ext * c_ext - y_ext * s_ext;
        py_full = x_ext * s_ext + y_ext * c_ext;
        px_sh   = px_full >>> ROM_WIDTH;
        py_sh   = py_full >>> ROM_WIDTH;
    end

    // Datapath. sin_id is registered so it stays stable for a whole WAIT
    // state. It is loaded on the accept edge and on the SIN->COS edge, and
    // it simply holds its value at all other times.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r     <= '0;
            y_r     <= '0;
            angle_r <= '0;
            s_r     <= '0;
            c_r     <= '0;
            sin_id  <= '0;
            out_x   <= '0;
            out_y   <= '0;
        end else begin
            if (accept) begin
                x_r     <= in_x;
                y_r     <= in_y;
                angle_r <= in_angle;
                sin_id  <= in_angle;
            end
            if (latch_s) begin
                s_r    <= sin_data;
                sin_id <= angle_r + ADDRW'(ROM_DEPTH);
            end
            if (latch_c)
                c_r <= sin_data;
            if (do_mult) begin
                out_x <= sat(px_sh);
                out_y <= sat(py_sh);
            end
        end
    end

endmodule

// File: tb/tb_point_rotator.sv
// tb_point_rotator
//   Bench for point_rotator at its default parameters. It contains a behavioural
//   model of the HIGH_PERFORMANCE sine_table: rounded 256*sin over a 256-code
//   circle, with two cycles of latency. Stimulus pushes the expected rotated
//   point into a queue. A separate monitor pops that queue and compares on each
//   output handshake.
module tb_point_rotator;

    localparam int CLK_P = 10;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_x, in_y;
    logic [7:0]  in_angle;
    logic [7:0]  sin_id;
    logic [15:0] sin_data;
    logic [15:0] tbl_s1;
    logic        out_valid;
    logic        out_ready;
    logic        out_ready_man;
    logic        rnd_bp;
    logic        rnd_bit;
    logic [10:0] out_x, out_y;

    typedef struct {
        int x;
        int y;
    } pt_t;

    pt_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    point_rotator #(
        .ROM_DEPTH(64),
        .ROM_WIDTH(8),
        .ADDRW(8),
        .COORD_W(11),
        .TABLE_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .in_y(in_y),
        .in_angle(in_angle),
        .sin_id(sin_id),
        .sin_data(sin_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x(out_x),
        .out_y(out_y)
    );

    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    // sin of code id, in Q8.8 (1.0 = 256), full circle = 256 codes.
    function automatic int tbl(input int id);
        real r;
        r = 256.0 * $sin(2.0 * 3.14159265358979 * real'(id % 256) / 256.0);
        return int'(r);
    endfunction

    // Two-cycle table pipeline.
    always @(posedge clk) begin
        tbl_s1   <= 16'(tbl(int'(sin_id)));
        sin_data <= tbl_s1;
    end

    // Random back-pressure is only applied during the random phase.
    always @(negedge clk) rnd_bit = ($urandom_range(0, 3) != 0);
    assign out_ready = rnd_bp ? rnd_bit : out_ready_man;

    function automatic longint floor_div256(input longint a);
        longint q;
        q = a / 256;
        if ((a % 256) != 0 && a < 0)
            q = q - 1;
        return q;
    endfunction

    function automatic int clamp11(input longint v);
        if (v > 1023)  return 1023;
        if (v < -1024) return -1024;
        return int'(v);
    endfunction

    // Rotation computed from the table's sin/cos values.
    function automatic pt_t model(input int x, input int y, input int a);
        pt_t    p;
        longint s, c;
        s   = longint'(tbl(a));
        c   = longint'(tbl(a + 64));
        p.x = clamp11(floor_div256(longint'(x) * c - longint'(y) * s));
        p.y = clamp11(floor_div256(longint'(x) * s + longint'(y) * c));
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: checks every output handshake against the queue head.
    initial begin
        pt_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_x", int'($signed(out_x)), 99999);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_x", int'($signed(out_x)), e.x);
                    chk("out_y", int'($signed(out_y)), e.y);
                end
            end
        end
    end

    time acc_t;

    // Present a request and wait, bounded, until it is accepted. The expected
    // result is queued just before the accepting edge. Returns right after
    // that edge (cycle 0).
    task automatic send(input int x, input int y, input int a, input pt_t e, input bit hold);
        int n;
        @(negedge clk);
        in_x     = 11'(x);
        in_y     = 11'(y);
        in_angle = 8'(a);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
            acc_t = $time;
            if (!hold) begin
                #1;
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((!in_ready || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready || exp_q.size() != 0)
            chk("idle_timeout", 0, 1);
    endtask

    function automatic pt_t mk(input int x, input int y);
        pt_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

    // Directed request with sin_id sequencing and out_valid latency checks.
    task automatic dir(input int a, input int x, input int y, input int ex, input int ey);
        int exp_id;
        send(x, y, a, mk(ex, ey), 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                exp_id = a % 256;
                chk("sin_id_sin", int'(sin_id), exp_id);
            end else if (k <= 6) begin
                exp_id = (a + 64) % 256;
                chk("sin_id_cos", int'(sin_id), exp_id);
            end else if (k == 7) begin
                chk("out_valid_c7", int'(out_valid), 0);
            end else begin
                chk("out_valid_c8", int'(out_valid), 1);
            end
        end
        wait_idle();
    endtask

    initial begin
        time t0, t1;
        int  n;
        int  rx, ry, ra;

        rst           = 1'b0;
        in_valid      = 1'b0;
        in_x          = '0;
        in_y          = '0;
        in_angle      = '0;
        out_ready_man = 1'b1;
        rnd_bp        = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sin_id", int'(sin_id), 0);
        chk("rst_out_x", int'($signed(out_x)), 0);
        chk("rst_out_y", int'($signed(out_y)), 0);
        rst = 1'b1;

        // Quadrant rotations.
        dir(0,   100, 50, 100,  50);
        dir(64,  100, 50, -50,  100);
        dir(128, 100, 50, -100, -50);
        dir(192, 100, 50, 50,   -100);

        // 45 degrees with saturation.
        dir(32, 1023, 1023, 0, 1023);
        dir(32, -1024, -1024, 0, -1024);

        // Back-pressure: result held for 5 cycles; input pulse ignored.
        out_ready_man = 1'b0;
        send(100, 50, 64, mk(-50, 100), 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_out", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_x", int'($signed(out_x)), -50);
            chk("bp_out_y", int'($signed(out_y)), 100);
            chk("bp_in_ready", int'(in_ready), 0);
            if (i == 1) begin
                in_x     = 11'(7);
                in_y     = 11'(9);
                in_angle = 8'(40);
                in_valid = 1'b1;
            end else if (i == 2) begin
                in_valid = 1'b0;
            end
        end
        out_ready_man = 1'b1;
        wait_idle();

        // Back-to-back with in_valid held: one accept every 9 cycles.
        send(300, -200, 10, model(300, -200, 10), 1'b1);
        t0 = acc_t;
        send(-500, 400, 77, model(-500, 400, 77), 1'b1);
        t1 = acc_t;
        chk("b2b_gap1", int'((t1 - t0) / CLK_P), 9);
        send(250, 250, 200, model(250, 250, 200), 1'b1);
        chk("b2b_gap2", int'((acc_t - t1) / CLK_P), 9);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset during COS_WAIT drops the transaction.
        send(50, -30, 100, model(50, -30, 100), 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_sin_id", int'(sin_id), 0);
        chk("mid_rst_out_x", int'($signed(out_x)), 0);
        chk("mid_rst_out_y", int'($signed(out_y)), 0);
        @(negedge clk);
        rst = 1'b1;
        send(-700, 123, 150, model(-700, 123, 150), 1'b0);
        wait_idle();

        // Randomized points, angles and back-pressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 25; i++) begin
            rx = int'($urandom_range(0, 2047)) - 1024;
            ry = int'($urandom_range(0, 2047)) - 1024;
            ra = int'($urandom_range(0, 255));
            send(rx, ry, ra, model(rx, ry, ra), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rnd_bp = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(CLK_P * 20000);
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
